// File: rtl/word_block_packer.sv
// Word-to-block packer: gathers NWORDS words of WSIZE bits into one block, with a flush for partial blocks.
// Optional feature macro: WBP_BLOCK_COUNT_EN adds a 16-bit block_count output of handshaked blocks.
module word_block_packer #(
  parameter  int WSIZE     = 32,
  parameter  int NWORDS    = 4,
  parameter  int MSW_FIRST = 1,
  localparam int BSIZE     = WSIZE * NWORDS,
  localparam int CNTW      = $clog2(NWORDS) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WSIZE-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             flush,
  output logic [BSIZE-1:0] block_out,
  output logic [CNTW-1:0]  block_words,
  output logic             block_valid,
`ifdef WBP_BLOCK_COUNT_EN
  output logic [15:0]      block_count,
`endif
  input  logic             block_ready
);

  logic [NWORDS-1:0][WSIZE-1:0] slots;
  logic [NWORDS-1:0][WSIZE-1:0] slots_next;
  logic [CNTW-1:0]              count;
  logic [CNTW-1:0]              eff_count;
  logic                         flush_pending;
  logic                         slot_free;
  logic                         accept;
  logic                         last_word;
  logic                         want_close;
  logic                         complete;
  logic [BSIZE-1:0]             packed_next;

  // The effective count and data include a word accepted this same cycle, so a close never loses it.
  always_comb begin
    slot_free  = !block_valid || block_ready;
    word_ready = slot_free || ((count < CNTW'(NWORDS - 1)) && !flush_pending);
    accept     = word_valid && word_ready;
    last_word  = accept && (count == CNTW'(NWORDS - 1));
    eff_count  = count + CNTW'(accept);
    want_close = last_word || ((flush || flush_pending) && (eff_count != '0));
    complete   = want_close && slot_free;

    slots_next = slots;
    if (accept) slots_next[count[CNTW-2:0]] = word_in;

    packed_next = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (MSW_FIRST != 0) packed_next[BSIZE-1-i*WSIZE -: WSIZE] = slots_next[i];
      else                packed_next[i*WSIZE +: WSIZE]         = slots_next[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slots         <= '0;
      count         <= '0;
      flush_pending <= 1'b0;
      block_out     <= '0;
      block_words   <= '0;
      block_valid   <= 1'b0;
    end else if (complete) begin
      block_out     <= packed_next;
      block_words   <= eff_count;
      block_valid   <= 1'b1;
      slots         <= '0;
      count         <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (block_ready) block_valid <= 1'b0;
      slots <= slots_next;
      count <= eff_count;
      // Reaching here with a non-empty flush means the output register is still occupied.
      if (flush && (eff_count != '0)) flush_pending <= 1'b1;
    end
  end

`ifdef WBP_BLOCK_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          block_count <= '0;
    else if (block_valid && block_ready) block_count <= block_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_word_block_packer.sv
// Randomised + directed self-checking bench for word_block_packer against a word-queue scoreboard.
// A second instance (WSIZE=16, NWORDS=8, MSW_FIRST=0) covers the LSW-first packing order.
module tb_word_block_packer;

  localparam int W = 32;
  localparam int N = 4;
  localparam int B = W * N;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] word_in = '0;
  logic         word_valid = 1'b0;
  logic         word_ready;
  logic         flush = 1'b0;
  logic [B-1:0] block_out;
  logic [2:0]   block_words;
  logic         block_valid;
  logic         block_ready = 1'b0;
`ifdef WBP_BLOCK_COUNT_EN
  logic [15:0]  block_count;
  logic [15:0]  block_count2;
`endif

  logic [15:0]  w2_in = '0;
  logic         w2_valid = 1'b0;
  logic         w2_ready;
  logic [127:0] b2_out;
  logic [3:0]   b2_words;
  logic         b2_valid;

  word_block_packer dut (
    .clock(clock), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .flush(flush), .block_out(block_out),
    .block_words(block_words), .block_valid(block_valid),
`ifdef WBP_BLOCK_COUNT_EN
    .block_count(block_count),
`endif
    .block_ready(block_ready)
  );

  word_block_packer #(.WSIZE(16), .NWORDS(8), .MSW_FIRST(0)) dut2 (
    .clock(clock), .reset(reset), .word_in(w2_in), .word_valid(w2_valid),
    .word_ready(w2_ready), .flush(1'b0), .block_out(b2_out),
    .block_words(b2_words), .block_valid(b2_valid),
`ifdef WBP_BLOCK_COUNT_EN
    .block_count(block_count2),
`endif
    .block_ready(1'b1)
  );

  always #5 clock = ~clock;

  int           checkCount = 0;
  int           failCount = 0;
  logic [W-1:0] accQ[$];
  int           flushCount = 0;
  int           partialSeen = 0;
  int           blocksConsumed = 0;
  logic         lastAccept = 1'b0;
  logic         holdValid = 1'b0;
  logic [B-1:0] heldOut = '0;
  logic [2:0]   heldWords = '0;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // A handshaked block must hold the next block_words words of the accepted stream, MSW first, rest zero.
  task automatic consumeBlock();
    logic [W-1:0] slot;
    logic [W-1:0] expWord;
    int k;
    k = int'(block_words);
    checkOutput("words_range", 128'((k >= 1) && (k <= N)), 128'd1);
    if (k < N) begin
      checkOutput("partial_has_flush", 128'(flushCount > partialSeen), 128'd1);
      partialSeen++;
    end
    for (int i = 0; i < N; i++) begin
      slot = block_out[B-1-i*W -: W];
      if (i < k) begin
        if (accQ.size() > 0) expWord = accQ.pop_front();
        else expWord = 'x;
        checkOutput("slot_data", 128'(slot), 128'(expWord));
      end else begin
        checkOutput("slot_zero", 128'(slot), 128'd0);
      end
    end
    blocksConsumed++;
  endtask

  // One clock cycle: drive inputs, observe the handshakes at the negedge, end at posedge+1.
  task automatic applyStimulus(input logic wv, input logic [W-1:0] w, input logic fl, input logic br);
    word_valid  = wv;
    word_in     = w;
    flush       = fl;
    block_ready = br;
    @(negedge clock);
    lastAccept = wv && word_ready;
    if (holdValid) begin
      checkOutput("hold_valid", 128'(block_valid), 128'd1);
      checkOutput("hold_out", 128'(block_out), 128'(heldOut));
      checkOutput("hold_words", 128'(block_words), 128'(heldWords));
    end
    holdValid = block_valid && !br;
    heldOut   = block_out;
    heldWords = block_words;
    if (block_valid && br) consumeBlock();
    if (lastAccept) accQ.push_back(w);
    if (fl) flushCount++;
    @(posedge clock);
    #1;
  endtask

  task automatic feedWord(input logic [W-1:0] w, input logic br);
    lastAccept = 1'b0;
    for (int t = 0; t < 20 && !lastAccept; t++) applyStimulus(1'b1, w, 1'b0, br);
    checkOutput("feed_accepted", 128'(lastAccept), 128'd1);
  endtask

  task automatic clearModel();
    accQ.delete();
    flushCount = 0;
    partialSeen = 0;
    blocksConsumed = 0;
    holdValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int startBlocks;
    #12;
    checkOutput("rst_valid", 128'(block_valid), 128'd0);
    checkOutput("rst_words", 128'(block_words), 128'd0);
    checkOutput("rst_out", 128'(block_out), 128'd0);
    checkOutput("rst_ready", 128'(word_ready), 128'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Full block with consumer always ready
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b1);
    checkOutput("t1_not_yet", 128'(block_valid), 128'd0);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b1);
    checkOutput("t1_valid", 128'(block_valid), 128'd1);
    checkOutput("t1_out", 128'(block_out), 128'h00000011_00000022_00000033_00000044);
    checkOutput("t1_words", 128'(block_words), 128'd4);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Partial block by flush, then a flush with nothing assembled
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("t2_valid", 128'(block_valid), 128'd1);
    checkOutput("t2_out", 128'(block_out), 128'h0000000A_0000000B_00000000_00000000);
    checkOutput("t2_words", 128'(block_words), 128'd2);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("t2_empty_flush", 128'(block_valid), 128'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t2_empty_flush2", 128'(block_valid), 128'd0);

    // Backpressure: second block stalls at its last word until the first drains
    startBlocks = blocksConsumed;
    for (int i = 1; i <= 7; i++) feedWord(32'h100 + 32'(i), 1'b0);
    applyStimulus(1'b1, 32'h108, 1'b0, 1'b0);
    checkOutput("t3_stall", 128'(lastAccept), 128'd0);
    applyStimulus(1'b1, 32'h108, 1'b0, 1'b0);
    checkOutput("t3_stall2", 128'(lastAccept), 128'd0);
    checkOutput("t3_held", 128'(block_out), 128'h00000101_00000102_00000103_00000104);
    feedWord(32'h108, 1'b1);
    checkOutput("t3_second", 128'(block_out), 128'h00000105_00000106_00000107_00000108);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t3_two_blocks", 128'(blocksConsumed - startBlocks), 128'd2);

    // LSW-first 8x16 instance
    for (int i = 0; i < 8; i++) begin
      w2_valid = 1'b1;
      w2_in = 16'(i);
      @(negedge clock);
      checkOutput("t4_ready", 128'(w2_ready), 128'd1);
      @(posedge clock);
      #1;
      if (i == 6) checkOutput("t4_not_yet", 128'(b2_valid), 128'd0);
    end
    w2_valid = 1'b0;
    checkOutput("t4_valid", 128'(b2_valid), 128'd1);
    checkOutput("t4_low", 128'(b2_out[15:0]), 128'd0);
    checkOutput("t4_high", 128'(b2_out[127:112]), 128'd7);
    checkOutput("t4_words", 128'(b2_words), 128'd8);

    // Flush while the output register is full
    for (int i = 1; i <= 5; i++) feedWord(32'h500 + 32'(i), 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h506, 1'b0, 1'b0);
    checkOutput("t5_pending_stall", 128'(lastAccept), 128'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t5_valid", 128'(block_valid), 128'd1);
    checkOutput("t5_words", 128'(block_words), 128'd1);
    checkOutput("t5_out", 128'(block_out), 128'h00000505_00000000_00000000_00000000);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Randomised traffic against the scoreboard
    for (int c = 0; c < 400; c++)
      applyStimulus(1'(($urandom % 10) < 7), $urandom, 1'(($urandom % 10) == 0), 1'(($urandom % 10) < 6));
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("rand_drained", 128'(accQ.size()), 128'd0);
    checkOutput("rand_idle", 128'(block_valid), 128'd0);

    // Asynchronous reset mid-block
    for (int i = 1; i <= 3; i++) feedWord(32'h600 + 32'(i), 1'b1);
    word_valid = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("t6_valid", 128'(block_valid), 128'd0);
    checkOutput("t6_words", 128'(block_words), 128'd0);
    checkOutput("t6_out", 128'(block_out), 128'd0);
    checkOutput("t6_ready", 128'(word_ready), 128'd1);
    clearModel();
    #3;
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 1; i <= 4; i++) feedWord(32'h700 + 32'(i), 1'b1);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t6_one_block", 128'(blocksConsumed), 128'd1);
    checkOutput("t6_model_empty", 128'(accQ.size()), 128'd0);
`ifdef WBP_BLOCK_COUNT_EN
    checkOutput("t6_block_count", 128'(block_count), 128'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
